// File: rtl/mem_req_issuer_pkg.sv
// mem_req_issuer_pkg: funct3 encodings, oprand bit positions, issuer FSM
// states and the helpers that judge and encode a queued request.
package mem_req_issuer_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int OPRAND_STROBE_BIT = 20;
  localparam int OPRAND_STORE_BIT  = 31;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Loads accept the five RV32I widths; stores only byte, half and word.
  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    if (store) begin
      return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    end
    return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
  endfunction

  // Strobe word for the controller: strobe, store flag and funct3, rest zero.
  function automatic logic [31:0] build_oprand(input logic store, input logic [2:0] funct3);
    logic [31:0] op;
    op = '0;
    op[OPRAND_STROBE_BIT] = 1'b1;
    op[OPRAND_STORE_BIT]  = store;
    op[2:0]               = funct3;
    return op;
  endfunction

endpackage

// File: rtl/mem_req_issuer_fifo.sv
// req_fifo: small synchronous request queue with wrap-bit pointers.
// The head is read straight from storage, so a pushed entry becomes visible
// only on the cycle after it is written (no flow-through). clear empties it.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry storage; contents of empty slots are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mem_req_issuer.sv
// mem_req_issuer: queues load/store requests and issues them one at a time
// to the unified icache/memory controller via the oprand[20] strobe, then
// returns the result and tag to the load/store buffer.
// Build option: define MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_err instead of issuing them.
module mem_req_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      mem_addr_in,
  output logic [31:0]      oprand,
  output logic [31:0]      mem_write_data,
  input  logic [1:0]       mem_ready,
  input  logic [31:0]      mem_data,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic             busy
);

  import mem_req_issuer_pkg::*;

  localparam int ENTRY_W = 1 + 3 + 32 + 32 + TAG_W;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               head_store;
  logic [2:0]         head_funct3;
  logic [31:0]        head_addr;
  logic [31:0]        head_wdata;
  logic [TAG_W-1:0]   head_tag;
  logic               head_legal;
  logic               align_ok;
  state_t             state;
  logic               saved_store;
  logic [TAG_W-1:0]   saved_tag;
  logic               unused_ok;

  // The controller's "ready" bit 0 carries nothing this issuer needs.
  assign unused_ok = mem_ready[0];

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full && rdy && !flush;
  assign pop       = rdy && !flush && (state == IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state != IDLE);

  assign {head_store, head_funct3, head_addr, head_wdata, head_tag} = head;

`ifdef MISALIGN_CHECK_EN
  // Halfwords need addr[0] clear, words need addr[1:0] clear.
  always_comb begin
    align_ok = 1'b1;
    if ((head_funct3[1:0] == 2'b01) && head_addr[0]) begin
      align_ok = 1'b0;
    end
    if ((head_funct3[1:0] == 2'b10) && (head_addr[1:0] != 2'b00)) begin
      align_ok = 1'b0;
    end
  end
`else
  assign align_ok = 1'b1;
`endif

  assign head_legal = funct3_legal(head_store, head_funct3) && align_ok;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({req_store, req_funct3, req_addr, req_wdata, req_tag}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM with registered controller and response outputs; flush beats rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mem_addr_in    <= '0;
      mem_write_data <= '0;
      oprand         <= '0;
      resp_valid     <= 1'b0;
      resp_tag       <= '0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
      saved_store    <= 1'b0;
      saved_tag      <= '0;
    end else if (flush) begin
      state      <= IDLE;
      oprand     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else if (rdy) begin
      oprand     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_legal) begin
              mem_addr_in    <= head_addr;
              mem_write_data <= head_wdata;
              oprand         <= build_oprand(head_store, head_funct3);
              saved_store    <= head_store;
              saved_tag      <= head_tag;
              state          <= WAIT;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_tag   <= head_tag;
              resp_data  <= '0;
            end
          end
        end
        WAIT: begin
          if (mem_ready[1]) begin
            resp_valid <= 1'b1;
            resp_tag   <= saved_tag;
            resp_data  <= saved_store ? 32'h0 : mem_data;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_issuer.sv
// tb_mem_req_issuer: directed self-checking bench for mem_req_issuer.
// Inputs change and outputs are checked on the falling clock edge.
// Define MISALIGN_CHECK_EN to exercise the alignment-rejection build.
module tb_mem_req_issuer;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_tag;
  logic [31:0] mem_addr_in;
  logic [31:0] oprand;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_ready;
  logic [31:0] mem_data;
  logic        resp_valid;
  logic [3:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int strobe_count = 0;
  int base;
  logic prev_strobe = 1'b0;

  mem_req_issuer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_tag        (req_tag),
    .mem_addr_in    (mem_addr_in),
    .oprand         (oprand),
    .mem_write_data (mem_write_data),
    .mem_ready      (mem_ready),
    .mem_data       (mem_data),
    .resp_valid     (resp_valid),
    .resp_tag       (resp_tag),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .busy           (busy)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Count distinct strobe pulses; a strobe held across a stall counts once.
  always @(negedge clk) begin
    if (oprand[20] && !prev_strobe) begin
      strobe_count <= strobe_count + 1;
    end
    prev_strobe <= oprand[20];
  end

  // Hard stop in case the directed sequence ever hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
    end
  endtask

  // Offer one request for a single cycle.
  task automatic applyStimulus(input logic store, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] tag);
    req_store  = store;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_tag    = tag;
    req_valid  = 1'b1;
    waitCycle();
    req_valid  = 1'b0;
  endtask

  // Wait (bounded) for the next strobe, check it, answer it and check the response.
  task automatic serviceRequest(input string name, input logic [31:0] exp_op,
                                input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                                input logic [3:0] exp_tag, input logic [31:0] data,
                                input logic [31:0] exp_data);
    for (int i = 0; i < 20; i++) begin
      if (oprand[20]) break;
      waitCycle();
    end
    checkOutput({name, "_strobe_seen"}, {31'd0, oprand[20]}, 32'd1);
    checkOutput({name, "_oprand"}, oprand, exp_op);
    checkOutput({name, "_addr"}, mem_addr_in, exp_addr);
    checkOutput({name, "_wdata"}, mem_write_data, exp_wdata);
    waitCycle();
    checkOutput({name, "_strobe_single"}, oprand, 32'h0);
    mem_ready = 2'b10;
    mem_data  = data;
    waitCycle();
    mem_ready = 2'b00;
    mem_data  = 32'h0;
    checkOutput({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({name, "_resp_tag"}, {28'd0, resp_tag}, {28'd0, exp_tag});
    checkOutput({name, "_resp_data"}, resp_data, exp_data);
    checkOutput({name, "_resp_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 4'h0;
    mem_ready = 2'b00; mem_data = 32'h0;

    // Reset state.
    waitCycle();
    waitCycle();
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_oprand", oprand, 32'h0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr_in, 32'h0);
    rst = 1'b0;
    waitCycle();

    // Single LW: strobe one edge after enqueue, response one cycle after mem_ready.
    $display("[TB] single load");
    base = strobe_count;
    applyStimulus(1'b0, F_LW, 32'h1000, 32'h0, 4'd3);
    checkOutput("t1_no_strobe_yet", oprand, 32'h0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    waitCycle();
    checkOutput("t1_oprand", oprand, 32'h0010_0002);
    checkOutput("t1_addr", mem_addr_in, 32'h1000);
    waitCycle();
    checkOutput("t1_strobe_single", oprand, 32'h0);
    waitCycle();
    waitCycle();
    mem_ready = 2'b11;
    mem_data  = 32'hDEAD_BEEF;
    checkOutput("t1_no_early_resp", {31'd0, resp_valid}, 32'd0);
    waitCycle();
    mem_ready = 2'b00;
    mem_data  = 32'h0;
    checkOutput("t1_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t1_resp_tag", {28'd0, resp_tag}, 32'd3);
    checkOutput("t1_resp_data", resp_data, 32'hDEAD_BEEF);
    checkOutput("t1_resp_err", {31'd0, resp_err}, 32'd0);
    waitCycle();
    checkOutput("t1_resp_pulse", {31'd0, resp_valid}, 32'd0);
    checkOutput("t1_idle", {31'd0, busy}, 32'd0);
    checkOutput("t1_strobe_count", strobe_count - base, 32'd1);

    // Fill the FIFO behind an outstanding load, then drain in order.
    $display("[TB] back-to-back requests");
    base = strobe_count;
    applyStimulus(1'b0, F_LW, 32'h30, 32'h0, 4'd6);
    applyStimulus(1'b1, F_SW, 32'h20, 32'hCAFE_F00D, 4'd1);
    checkOutput("t2_first_oprand", oprand, 32'h0010_0002);
    checkOutput("t2_first_addr", mem_addr_in, 32'h30);
    applyStimulus(1'b0, F_LB, 32'h21, 32'h0, 4'd2);
    applyStimulus(1'b1, F_SH, 32'h22, 32'h0000_ABCD, 4'd4);
    checkOutput("t2_ready_before_4th", {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b0, F_LHU, 32'h24, 32'h0, 4'd5);
    checkOutput("t2_full", {31'd0, req_ready}, 32'd0);
    applyStimulus(1'b0, F_LW, 32'h28, 32'h0, 4'd7);
    checkOutput("t2_still_full", {31'd0, req_ready}, 32'd0);
    mem_ready = 2'b10;
    mem_data  = 32'h1111_2222;
    waitCycle();
    mem_ready = 2'b00;
    checkOutput("t2_lw_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t2_lw_resp_tag", {28'd0, resp_tag}, 32'd6);
    checkOutput("t2_lw_resp_data", resp_data, 32'h1111_2222);
    checkOutput("t2_full_until_pop", {31'd0, req_ready}, 32'd0);
    serviceRequest("t2_sw", 32'h8010_0002, 32'h20, 32'hCAFE_F00D, 4'd1, 32'h5555_5555, 32'h0);
    checkOutput("t2_ready_after_pop", {31'd0, req_ready}, 32'd1);
    serviceRequest("t2_lb", 32'h0010_0000, 32'h21, 32'h0, 4'd2, 32'hFFFF_FF80, 32'hFFFF_FF80);
    serviceRequest("t2_sh", 32'h8010_0001, 32'h22, 32'h0000_ABCD, 4'd4, 32'h7777_7777, 32'h0);
    serviceRequest("t2_lhu", 32'h0010_0005, 32'h24, 32'h0, 4'd5, 32'h0000_BEEF, 32'h0000_BEEF);
    waitCycle();
    checkOutput("t2_idle", {31'd0, busy}, 32'd0);
    checkOutput("t2_strobe_count", strobe_count - base, 32'd5);

    // Flush while waiting, with a queued entry and an enqueue attempt; stale completion ignored.
    $display("[TB] flush");
    base = strobe_count;
    applyStimulus(1'b0, F_LW, 32'h40, 32'h0, 4'd8);
    applyStimulus(1'b0, F_LW, 32'h44, 32'h0, 4'd9);
    checkOutput("t3_strobe", oprand, 32'h0010_0002);
    waitCycle();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h48;
    req_tag   = 4'd15;
    waitCycle();
    flush     = 1'b0;
    req_valid = 1'b0;
    checkOutput("t3_flush_resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("t3_flush_oprand", oprand, 32'h0);
    checkOutput("t3_flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("t3_flush_ready", {31'd0, req_ready}, 32'd1);
    waitCycle();
    mem_ready = 2'b10;
    mem_data  = 32'hBAD0_BAD0;
    waitCycle();
    mem_ready = 2'b00;
    checkOutput("t3_stale_resp", {31'd0, resp_valid}, 32'd0);
    waitCycle();
    checkOutput("t3_stale_resp2", {31'd0, resp_valid}, 32'd0);
    checkOutput("t3_busy", {31'd0, busy}, 32'd0);
    checkOutput("t3_strobe_count", strobe_count - base, 32'd1);

    // Illegal store funct3 is rejected without a strobe; next request issues.
    $display("[TB] illegal funct3");
    base = strobe_count;
    applyStimulus(1'b1, 3'b100, 32'h50, 32'h99, 4'd10);
    applyStimulus(1'b0, F_LW, 32'h60, 32'h0, 4'd11);
    checkOutput("t4_err_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t4_err_flag", {31'd0, resp_err}, 32'd1);
    checkOutput("t4_err_tag", {28'd0, resp_tag}, 32'd10);
    checkOutput("t4_err_data", resp_data, 32'h0);
    checkOutput("t4_err_no_strobe", oprand, 32'h0);
    serviceRequest("t4_next", 32'h0010_0002, 32'h60, 32'h0, 4'd11, 32'h0BAD_F00D, 32'h0BAD_F00D);
    waitCycle();
    checkOutput("t4_strobe_count", strobe_count - base, 32'd1);

    // Stall: strobe held over rdy=0, then a response held over a 3-cycle stall.
    $display("[TB] rdy stall");
    base = strobe_count;
    applyStimulus(1'b0, F_LW, 32'h70, 32'h0, 4'd12);
    waitCycle();
    checkOutput("t5_strobe", oprand, 32'h0010_0002);
    rdy = 1'b0;
    waitCycle();
    checkOutput("t5_strobe_held1", oprand, 32'h0010_0002);
    waitCycle();
    checkOutput("t5_strobe_held2", oprand, 32'h0010_0002);
    rdy = 1'b1;
    waitCycle();
    checkOutput("t5_strobe_drop", oprand, 32'h0);
    mem_ready = 2'b10;
    mem_data  = 32'h1234_5678;
    waitCycle();
    mem_ready = 2'b00;
    mem_data  = 32'h0;
    checkOutput("t5_resp_valid", {31'd0, resp_valid}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("t5_resp_held", {31'd0, resp_valid}, 32'd1);
      checkOutput("t5_no_strobe_in_stall", oprand, 32'h0);
    end
    checkOutput("t5_resp_tag", {28'd0, resp_tag}, 32'd12);
    checkOutput("t5_resp_data", resp_data, 32'h1234_5678);
    rdy = 1'b1;
    waitCycle();
    checkOutput("t5_resp_done", {31'd0, resp_valid}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_strobe_count", strobe_count - base, 32'd1);

    // Misaligned LW: rejected when the alignment check is built in, issued otherwise.
    $display("[TB] misaligned word");
    base = strobe_count;
    applyStimulus(1'b0, F_LW, 32'h1002, 32'h0, 4'd13);
`ifdef MISALIGN_CHECK_EN
    waitCycle();
    checkOutput("t6_err_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("t6_err_flag", {31'd0, resp_err}, 32'd1);
    checkOutput("t6_err_tag", {28'd0, resp_tag}, 32'd13);
    checkOutput("t6_no_strobe", oprand, 32'h0);
    waitCycle();
    checkOutput("t6_strobe_count", strobe_count - base, 32'd0);
`else
    serviceRequest("t6_issue", 32'h0010_0002, 32'h1002, 32'h0, 4'd13, 32'h2468_ACE0, 32'h2468_ACE0);
    waitCycle();
    checkOutput("t6_strobe_count", strobe_count - base, 32'd1);
`endif
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-WAIT abandons the access with no response.
    $display("[TB] async reset in WAIT");
    base = strobe_count;
    applyStimulus(1'b0, F_LW, 32'h80, 32'h0, 4'd14);
    waitCycle();
    waitCycle();
    checkOutput("t7_waiting", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t7_async_busy", {31'd0, busy}, 32'd0);
    checkOutput("t7_async_addr", mem_addr_in, 32'h0);
    waitCycle();
    rst = 1'b0;
    mem_ready = 2'b10;
    mem_data  = 32'hFACE_FACE;
    waitCycle();
    mem_ready = 2'b00;
    checkOutput("t7_no_resp", {31'd0, resp_valid}, 32'd0);
    waitCycle();
    checkOutput("t7_no_resp2", {31'd0, resp_valid}, 32'd0);
    checkOutput("t7_strobe_count", strobe_count - base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
